// File: rtl/instruction_decoder.sv
// MIPS-I decode-stage field extractor and load/store/ALU classifier.
// Every output is registered, so results appear one clk edge after instr is sampled.
module instruction_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic        is_load,
  output logic        is_store,
  output logic        is_alu
);

  localparam int N_ALU_FUNCT = 16;

  // SPECIAL (opcode 0) funct codes that are plain ALU operations.
  localparam logic [5:0] ALU_FUNCT [N_ALU_FUNCT] = '{
    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
    6'h20, 6'h21, 6'h22, 6'h23,
    6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B
  };

  logic [5:0]             op_field;
  logic [5:0]             funct_field;
  logic [N_ALU_FUNCT-1:0] funct_hit;
  logic                   is_load_next;
  logic                   is_store_next;
  logic                   is_alu_next;

  logic [5:0]  opcode_reg;
  logic [4:0]  rs_reg;
  logic [4:0]  rt_reg;
  logic [4:0]  rd_reg;
  logic [15:0] imm_reg;
  logic        is_load_reg;
  logic        is_store_reg;
  logic        is_alu_reg;

  assign op_field    = instr[31:26];
  assign funct_field = instr[5:0];

  // One comparator per recognised funct code; any hit marks an R-type ALU op.
  generate
    for (genvar gi = 0; gi < N_ALU_FUNCT; gi++) begin : g_funct
      assign funct_hit[gi] = (funct_field == ALU_FUNCT[gi]);
    end
  endgenerate

  // The opcode case is exclusive, so at most one class flag can be set.
  always_comb begin
    is_load_next  = 1'b0;
    is_store_next = 1'b0;
    is_alu_next   = 1'b0;
    case (op_field)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load_next  = 1'b1;
      6'h28, 6'h29, 6'h2B:               is_store_next = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:        is_alu_next   = 1'b1;
      6'h00:                             is_alu_next   = |funct_hit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_reg   <= '0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      rd_reg       <= '0;
      imm_reg      <= '0;
      is_load_reg  <= 1'b0;
      is_store_reg <= 1'b0;
      is_alu_reg   <= 1'b0;
    end else begin
      opcode_reg   <= op_field;
      rs_reg       <= instr[25:21];
      rt_reg       <= instr[20:16];
      rd_reg       <= instr[15:11];
      imm_reg      <= instr[15:0];
      is_load_reg  <= is_load_next;
      is_store_reg <= is_store_next;
      is_alu_reg   <= is_alu_next;
    end
  end

  assign opcode   = opcode_reg;
  assign rs       = rs_reg;
  assign rt       = rt_reg;
  assign rd       = rd_reg;
  assign imm      = imm_reg;
  assign is_load  = is_load_reg;
  assign is_store = is_store_reg;
  assign is_alu   = is_alu_reg;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: hand-derived vector table, reset/back-to-back
// sequences, and random words checked against an independent classifier.
module tb_instruction_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        is_load;
  logic        is_store;
  logic        is_alu;

  instruction_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .opcode   (opcode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .imm      (imm),
    .is_load  (is_load),
    .is_store (is_store),
    .is_alu   (is_alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        ld;
    logic        st;
    logic        alu;
  } vec_t;

  localparam int N_VEC = 18;
  vec_t vecs [N_VEC];

  logic [39:0] exp_q [$];
  int          n_checks = 0;
  int          n_passed = 0;

  function automatic logic [39:0] actual_bundle();
    return {opcode, rs, rt, rd, imm, is_load, is_store, is_alu};
  endfunction

  // Reference classifier written from the opcode/funct lists.
  function automatic logic [39:0] ref_decode(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    logic       ld;
    logic       st;
    logic       alu;
    op  = w[31:26];
    fn  = w[5:0];
    ld  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    st  = op inside {6'h28, 6'h29, 6'h2B};
    alu = (op >= 6'h08 && op <= 6'h0F) ||
          (op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                      [6'h20:6'h27], 6'h2A, 6'h2B}));
    return {op, w[25:21], w[20:16], w[15:11], w[15:0], ld, st, alu};
  endfunction

  task automatic check_val(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) begin
      n_passed++;
      $display("ok   %-12s instr=%08h got=%010h", name, instr, act);
    end else begin
      $display("FAIL %-12s instr=%08h got=%010h expected=%010h", name, instr, act, exp);
    end
  endtask

  task automatic check_pop(input string name);
    logic [39:0] exp;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %-12s scoreboard empty got=%010h expected=entry", name, actual_bundle());
    end else begin
      exp = exp_q.pop_front();
      check_val(name, actual_bundle(), exp);
    end
  endtask

  task automatic check_onehot(input string name);
    n_checks++;
    if ($countones({is_load, is_store, is_alu}) <= 1) begin
      n_passed++;
    end else begin
      $display("FAIL %-12s flags=%03b expected=at most one set", name, {is_load, is_store, is_alu});
    end
  endtask

  // Drive on the falling edge, compare just after the rising edge that captures it.
  task automatic drive(input logic [31:0] w, input logic [39:0] exp);
    @(negedge clk);
    instr = w;
    exp_q.push_back(exp);
  endtask

  initial begin
    vecs[0]  = '{32'h8C430004, 6'h23, 5'd2,  5'd3,  5'd0,  16'h0004, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'hAC430008, 6'h2B, 5'd2,  5'd3,  5'd0,  16'h0008, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h00430820, 6'h00, 5'd2,  5'd3,  5'd1,  16'h0820, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'h00400008, 6'h00, 5'd2,  5'd0,  5'd0,  16'h0008, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h2022FFFF, 6'h08, 5'd1,  5'd2,  5'd31, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'h10430003, 6'h04, 5'd2,  5'd3,  5'd0,  16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h00000000, 6'h00, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{32'h80000000, 6'h20, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'hA0000000, 6'h28, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h3C01ABCD, 6'h0F, 5'd0,  5'd1,  5'd21, 16'hABCD, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'h1C000000, 6'h07, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h40000000, 6'h10, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h00000001, 6'h00, 5'd0,  5'd0,  5'd0,  16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h0000002B, 6'h00, 5'd0,  5'd0,  5'd0,  16'h002B, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{32'h00000018, 6'h00, 5'd0,  5'd0,  5'd0,  16'h0018, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{32'h0000000C, 6'h00, 5'd0,  5'd0,  5'd0,  16'h000C, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{32'h88000000, 6'h22, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{32'hB0000000, 6'h2C, 5'd0,  5'd0,  5'd0,  16'h0000, 1'b0, 1'b0, 1'b0};

    // Reset with a load word present: outputs cleared without a clock edge.
    rst   = 1'b0;
    instr = 32'h8C430004;
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_async", actual_bundle(), 40'h0);
    @(posedge clk);
    #1;
    check_val("rst_held", actual_bundle(), 40'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({6'h23, 5'd2, 5'd3, 5'd0, 16'h0004, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    check_pop("rst_release");

    // Table vectors, back-to-back on consecutive edges.
    for (int i = 0; i < N_VEC; i++) begin
      drive(vecs[i].instr, {vecs[i].opcode, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                            vecs[i].imm, vecs[i].ld, vecs[i].st, vecs[i].alu});
      @(posedge clk);
      #1;
      check_pop($sformatf("vec%0d", i));
    end

    // Reset between edges mid-stream, then release with a new word waiting.
    drive(32'hAC430008, {6'h2B, 5'd2, 5'd3, 5'd0, 16'h0008, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #1;
    check_pop("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst", actual_bundle(), 40'h0);
    exp_q.delete();
    @(negedge clk);
    instr = 32'h00430820;
    rst   = 1'b0;
    exp_q.push_back({6'h00, 5'd2, 5'd3, 5'd1, 16'h0820, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    check_pop("post_rst");

    // Random words, with opcodes biased toward the interesting classes.
    for (int i = 0; i < 48; i++) begin
      logic [31:0] w;
      logic [5:0]  pick [8];
      pick = '{6'h00, 6'h08, 6'h0F, 6'h20, 6'h23, 6'h2B, 6'h29, 6'h25};
      w = $urandom;
      if (i % 3 == 0) w[31:26] = pick[$urandom_range(0, 7)];
      if (i % 4 == 1) begin
        w[31:26] = 6'h00;
        w[5:0]   = 6'($urandom_range(0, 6'h2F));
      end
      drive(w, ref_decode(w));
      @(posedge clk);
      #1;
      check_pop($sformatf("rand%0d", i));
      check_onehot($sformatf("onehot%0d", i));
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
